// File: rtl/ram_arb_pkg.sv
// Shared types and width helpers for the RAM arbiter and its round-robin picker.
package ram_arb_pkg;

  typedef enum logic [0:0] {
    ARB  = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first requester after last_grant, wrapping.
module rr_pick
  import ram_arb_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int IW      = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx
);

  logic found;
  int   cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_grant) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter with bounded lock in front of a single-port registered-output RAM.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12,
  parameter int NUM_REQ       = 2,
  parameter int MAX_HOLD      = 16
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0]               req_wen,
  input  logic [NUM_REQ-1:0]               req_lock,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             ram_wEn,
  output logic [ADDRESS_WIDTH-1:0]         ram_addr,
  output logic [DATA_WIDTH-1:0]            ram_dataIn,
  input  logic [DATA_WIDTH-1:0]            ram_dataOut,
  output arb_state_e                       dbg_state
);

  localparam int IW = idx_width(NUM_REQ);
  localparam int HW = idx_width(MAX_HOLD + 1);
  localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQ - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  // Handshake: a beat for requester i transfers in any cycle where req_valid[i]
  // and req_ready[i] are both high; the requester keeps valid, wen, lock, addr and
  // wdata stable until then. Ready is combinational and at most one bit is set.

  arb_state_e         state_q, state_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [IW-1:0]      last_grant_q, last_grant_d;
  logic [HW-1:0]      hold_cnt_q, hold_cnt_d;
  logic               rd_pend_q, rd_pend_d;
  logic [IW-1:0]      rd_owner_q, rd_owner_d;

  logic [NUM_REQ-1:0] rr_grant, grant;
  logic [IW-1:0]      rr_idx, sel;
  logic               accept;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (rr_grant),
    .grant_idx  (rr_idx)
  );

  // Grants are suppressed while reset is held so every output reads zero.
  always_comb begin
    grant = '0;
    sel   = rr_idx;
    if (!reset_n) begin
      grant = '0;
    end else if (state_q == ARB) begin
      grant = rr_grant;
    end else begin
      sel            = owner_q;
      grant[owner_q] = req_valid[owner_q];
    end
    accept = |grant;
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    hold_cnt_d   = hold_cnt_q;
    last_grant_d = accept ? sel : last_grant_q;
    rd_pend_d    = accept & ~req_wen[sel];
    rd_owner_d   = accept ? sel : rd_owner_q;
    case (state_q)
      ARB: begin
        if (accept && req_lock[sel]) begin
          state_d    = HOLD;
          owner_d    = sel;
          hold_cnt_d = HW'(1);
        end
      end
      HOLD: begin
        if ((accept && !req_lock[sel]) || (hold_cnt_q == HOLD_MAX)) begin
          state_d    = ARB;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ARB;
      owner_q      <= '0;
      last_grant_q <= LAST_RST;
      hold_cnt_q   <= '0;
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      hold_cnt_q   <= hold_cnt_d;
      rd_pend_q    <= rd_pend_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  always_comb begin
    req_ready  = grant;
    ram_wEn    = accept & req_wen[sel];
    ram_addr   = accept ? req_addr[sel*ADDRESS_WIDTH +: ADDRESS_WIDTH] : '0;
    ram_dataIn = accept ? req_wdata[sel*DATA_WIDTH +: DATA_WIDTH] : '0;
    rsp_valid  = '0;
    if (rd_pend_q) rsp_valid[rd_owner_q] = 1'b1;
    rsp_rdata  = rd_pend_q ? ram_dataOut : '0;
    dbg_state  = state_q;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed and randomized bench for ram_arbiter with a behavioural RAM and arbitration model.
module tb_ram_arbiter;
  import ram_arb_pkg::*;

  localparam int DW = 32;
  localparam int AW = 12;
  localparam int N  = 2;
  localparam int MH = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req_valid, req_ready, req_wen, req_lock, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, ram_dataIn, ram_dataOut;
  logic            ram_wEn;
  logic [AW-1:0]   ram_addr;
  arb_state_e      dbg_state;

  int total = 0;
  int bad   = 0;

  ram_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_REQ(N), .MAX_HOLD(MH)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .ram_wEn(ram_wEn), .ram_addr(ram_addr), .ram_dataIn(ram_dataIn), .ram_dataOut(ram_dataOut),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Registered-output single-port RAM (read-before-write).
  logic [DW-1:0] ram_mem [0:255];
  always @(posedge clk) begin
    ram_dataOut <= ram_mem[ram_addr[7:0]];
    if (ram_wEn) ram_mem[ram_addr[7:0]] <= ram_dataIn;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic v, input logic w, input logic l,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]           = v;
    req_wen[i]             = w;
    req_lock[i]            = l;
    req_addr[i*AW +: AW]   = a;
    req_wdata[i*DW +: DW]  = d;
  endtask

  task automatic new_cmd(input int i);
    set_req(i, 1'b1, 1'(($urandom_range(0, 1))), ($urandom_range(0, 3) == 0),
            AW'($urandom_range(0, 15)), $urandom);
  endtask

  // scoreboard state
  logic [DW-1:0] exp_q[$];
  int            own_q[$];
  logic [DW-1:0] model_mem [0:15];
  logic [DW-1:0] e_data;
  logic [AW-1:0] a_tmp;
  logic [N-1:0]  exp_rdy;
  int            e_own, g, j, m_last, m_owner, m_held, max_wait, blocked, granted;
  int            wait_c [N];

  initial begin
    reset_n   = 1'b0;
    req_valid = '0; req_wen = '0; req_lock = '0; req_addr = '0; req_wdata = '0;

    // Reset with every requester valid: nothing may leak out.
    set_req(0, 1'b1, 1'b1, 1'b0, 12'h005, 32'h1111_2222);
    set_req(1, 1'b1, 1'b0, 1'b0, 12'h006, 32'h0);
    repeat (2) mid();
    chk("rst_ready", req_ready, '0);
    chk("rst_rsp_valid", rsp_valid, '0);
    chk("rst_rsp_rdata", rsp_rdata, '0);
    chk("rst_ram_wen", ram_wEn, 1'b0);
    chk("rst_ram_addr", ram_addr, '0);
    chk("rst_ram_din", ram_dataIn, '0);
    chk("rst_state", dbg_state, ARB);

    next_cyc();
    reset_n = 1'b1;
    req_wen = '0;
    for (int k = 0; k < 4; k++) begin
      mid();
      chk("rr_alternate", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      next_cyc();
    end
    req_valid = '0;
    mid();
    next_cyc();

    // Write by requester 0 followed immediately by a read from requester 1.
    set_req(0, 1'b1, 1'b1, 1'b0, 12'h010, 32'hDEAD_BEEF);
    mid();
    chk("wr_ready", req_ready, 2'b01);
    chk("wr_ram_wen", ram_wEn, 1'b1);
    chk("wr_ram_addr", ram_addr, 12'h010);
    chk("wr_ram_din", ram_dataIn, 32'hDEAD_BEEF);
    next_cyc();
    set_req(0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
    set_req(1, 1'b1, 1'b0, 1'b0, 12'h010, 32'h0);
    mid();
    chk("rd_ready", req_ready, 2'b10);
    chk("rd_ram_wen", ram_wEn, 1'b0);
    chk("wr_no_rsp", rsp_valid, 2'b00);
    next_cyc();
    req_valid = '0;
    mid();
    chk("rd_rsp_valid", rsp_valid, 2'b10);
    chk("rd_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
    chk("idle_ram_addr", ram_addr, '0);
    next_cyc();

    // Requester 1 locks for three beats while requester 0 waits.
    set_req(0, 1'b1, 1'b0, 1'b0, 12'h020, 32'h0);
    mid();
    chk("pre_lock_r0", req_ready, 2'b01);
    next_cyc();
    for (int k = 0; k < 3; k++) begin
      set_req(1, 1'b1, 1'b1, (k < 2), AW'(12'h030 + k), 32'hA000_0000 + k);
      mid();
      chk("lock_ready", req_ready, 2'b10);
      if (k > 0) chk("lock_state", dbg_state, HOLD);
      next_cyc();
    end
    set_req(1, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
    mid();
    chk("unlock_r0", req_ready, 2'b01);
    chk("unlock_state", dbg_state, ARB);
    next_cyc();
    req_valid = '0;
    mid();
    next_cyc();

    // Requester 0 locks then goes idle: requester 1 waits out MAX_HOLD cycles.
    set_req(0, 1'b1, 1'b0, 1'b1, 12'h040, 32'h0);
    mid();
    chk("maxhold_lock", req_ready, 2'b01);
    next_cyc();
    set_req(0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
    set_req(1, 1'b1, 1'b0, 1'b0, 12'h041, 32'h0);
    blocked = 0;
    granted = 0;
    for (int k = 0; k < 10 && granted == 0; k++) begin
      mid();
      if (req_ready[1]) granted = 1;
      else begin
        blocked++;
        next_cyc();
      end
    end
    chk("maxhold_granted", granted, 1);
    chk("maxhold_blocked", blocked, MH);
    next_cyc();
    req_valid = '0;
    mid();
    next_cyc();

    // Reset while holding a lock with a read response pending.
    set_req(0, 1'b1, 1'b0, 1'b1, 12'h010, 32'h0);
    mid();
    chk("rst2_lock", req_ready, 2'b01);
    next_cyc();
    chk("rst2_pre_state", dbg_state, HOLD);
    chk("rst2_pre_rsp", rsp_valid, 2'b01);
    reset_n = 1'b0;
    set_req(1, 1'b1, 1'b0, 1'b0, 12'h011, 32'h0);
    req_lock = '0;
    mid();
    chk("rst2_rsp_valid", rsp_valid, 2'b00);
    chk("rst2_state", dbg_state, ARB);
    chk("rst2_ready", req_ready, 2'b00);
    next_cyc();
    reset_n = 1'b1;
    mid();
    chk("rst2_first", req_ready, 2'b01);
    chk("rst2_no_rsp", rsp_valid, 2'b00);
    next_cyc();
    req_valid = '0;

    // Preload the random-traffic address range through the arbiter.
    for (int a = 0; a < 16; a++) begin
      model_mem[a] = $urandom;
      set_req(0, 1'b1, 1'b1, 1'b0, AW'(a), model_mem[a]);
      mid();
      chk("preload_wen", ram_wEn, 1'b1);
      next_cyc();
    end
    req_valid = '0;
    reset_n   = 1'b0;
    mid();
    next_cyc();
    reset_n   = 1'b1;

    // Random traffic against the arbitration and memory model.
    m_last   = N - 1;
    m_owner  = -1;
    m_held   = 0;
    max_wait = 0;
    for (int i = 0; i < N; i++) wait_c[i] = 0;
    for (int cy = 0; cy < 10000; cy++) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 1) == 1) new_cmd(i);
      mid();

      if (exp_q.size() > 0) begin
        e_data = exp_q.pop_front();
        e_own  = own_q.pop_front();
        chk("rand_rsp_valid", rsp_valid, N'(1) << e_own);
        chk("rand_rsp_rdata", rsp_rdata, e_data);
      end else begin
        chk("rand_rsp_idle", rsp_valid, '0);
        chk("rand_rdata_idle", rsp_rdata, '0);
      end

      g = -1;
      if (m_owner >= 0) begin
        if (req_valid[m_owner]) g = m_owner;
      end else begin
        for (int k = 1; k <= N; k++) begin
          j = (m_last + k) % N;
          if (g < 0 && req_valid[j]) g = j;
        end
      end
      exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
      chk("rand_ready", req_ready, exp_rdy);
      chk("rand_ram_wen", ram_wEn, (g >= 0) ? req_wen[g] : 1'b0);
      chk("rand_ram_addr", ram_addr, (g >= 0) ? req_addr[g*AW +: AW] : '0);
      chk("rand_ram_din", ram_dataIn, (g >= 0) ? req_wdata[g*DW +: DW] : '0);

      if (g >= 0) begin
        a_tmp = req_addr[g*AW +: AW];
        if (req_wen[g]) model_mem[a_tmp[3:0]] = req_wdata[g*DW +: DW];
        else begin
          exp_q.push_back(model_mem[a_tmp[3:0]]);
          own_q.push_back(g);
        end
        m_last = g;
      end

      if (m_owner >= 0) begin
        m_held++;
        if ((g == m_owner && !req_lock[g]) || m_held == MH) m_owner = -1;
      end else if (g >= 0 && req_lock[g]) begin
        m_owner = g;
        m_held  = 0;
      end

      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && !req_ready[i]) wait_c[i]++;
        else wait_c[i] = 0;
        if (wait_c[i] > max_wait) max_wait = wait_c[i];
      end

      next_cyc();
      if (g >= 0) begin
        if ($urandom_range(0, 3) == 0) req_valid[g] = 1'b0;
        else new_cmd(g);
      end
    end
    chk("starvation_bound", (max_wait <= N * MH), 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
